// File: rtl/qea_run_sequencer.sv
// rtl/qea_run_sequencer.sv - one-shot QEA run controller: context load, state init, start, wait, readback
module qea_run_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int TIMEOUT_CYCLES          = 2**24
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
  input  logic                                 i_ctx_valid,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_ctx_ready,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  output logic                                 o_start,
  input  logic                                 i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 o_rd_valid,
  output logic [STATE_ADDR_WIDTH-1:0]          o_rd_addr,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_error,
  output logic [31:0]                          o_run_cycles
);

  localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_CTX = 3'd1;
  localparam logic [2:0] S_INIT     = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_RUN      = 3'd4;
  localparam logic [2:0] S_READ     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
  localparam logic [GATE_CONTEXT_ADDR_WIDTH:0] CTX_ONE = {{GATE_CONTEXT_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [STATE_ADDR_WIDTH:0] ROW_ONE = {{STATE_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  // |0...0>: amplitude 1.0 + 0i in the top slot of row 0, everything else zero
  localparam logic [ROW_W-1:0] INIT_ROW0 = {
    {(DATA_WIDTH-NUM_FRAC_BIT-1){1'b0}}, 1'b1, {NUM_FRAC_BIT{1'b0}},
    {DATA_WIDTH{1'b0}},
    {((PE_NUM-1)*STATE_DATA_WIDTH){1'b0}}
  };

  logic [2:0]                         state;
  logic [GATE_CONTEXT_ADDR_WIDTH:0]   ins_q;
  logic [GATE_CONTEXT_ADDR_WIDTH:0]   ctx_cnt;
  logic [STATE_ADDR_WIDTH:0]          rows_q;
  logic [STATE_ADDR_WIDTH:0]          row_cnt;
  logic [31:0]                        run_cnt;
  logic                               qbit_err_q;
  logic                               qbit_ok;
  logic [MAX_QBIT_WIDTH-1:0]          row_shift;
  logic [STATE_ADDR_WIDTH:0]          rows_next;
  logic                               timeout_hit;

  assign qbit_ok   = (i_qbit_num >= QBIT_MIN) && (i_qbit_num <= QBIT_MAX);
  assign row_shift = i_qbit_num - QBIT_MIN;
  assign rows_next = ROW_ONE << row_shift;

  // Completion wins over timeout when both land on the same cycle
  assign timeout_hit = (state == S_RUN) && !i_complete && ((run_cnt + 32'd1) == TIMEOUT_LIMIT);

  assign o_ctx_ready = (state == S_LOAD_CTX);
  assign o_start     = (state == S_START);
  assign o_busy      = (state != S_IDLE);
  assign o_done      = (state == S_DONE);
  assign o_error     = qbit_err_q | timeout_hit;
  assign o_rd_data   = o_rd_valid ? i_state_dout : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ins_q         <= '0;
      ctx_cnt       <= '0;
      rows_q        <= '0;
      row_cnt       <= '0;
      run_cnt       <= '0;
      qbit_err_q    <= 1'b0;
      o_ctx_en      <= 1'b0;
      o_ctx_wea     <= 1'b0;
      o_ctx_addr    <= '0;
      o_ctx_data    <= '0;
      o_state_ena   <= 1'b0;
      o_state_wea   <= 1'b0;
      o_state_addra <= '0;
      o_state_dina  <= '0;
      o_rd_valid    <= 1'b0;
      o_rd_addr     <= '0;
      o_run_cycles  <= '0;
    end else begin
      o_ctx_en    <= 1'b0;
      o_ctx_wea   <= 1'b0;
      o_state_ena <= 1'b0;
      o_state_wea <= 1'b0;
      qbit_err_q  <= 1'b0;
      // RAM read data arrives one cycle after the registered read address
      o_rd_valid  <= o_state_ena & ~o_state_wea;
      if (o_state_ena && !o_state_wea) o_rd_addr <= o_state_addra;

      case (state)
        S_IDLE: begin
          if (i_go) begin
            if (!qbit_ok) begin
              qbit_err_q <= 1'b1;
            end else begin
              ins_q   <= i_ins_num;
              rows_q  <= rows_next;
              ctx_cnt <= '0;
              row_cnt <= '0;
              state   <= (i_ins_num == '0) ? S_INIT : S_LOAD_CTX;
            end
          end
        end
        S_LOAD_CTX: begin
          if (i_ctx_valid) begin
            o_ctx_en   <= 1'b1;
            o_ctx_wea  <= 1'b1;
            o_ctx_addr <= ctx_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0];
            o_ctx_data <= i_ctx_data;
            ctx_cnt    <= ctx_cnt + CTX_ONE;
            if ((ctx_cnt + CTX_ONE) == ins_q) state <= S_INIT;
          end
        end
        S_INIT: begin
          o_state_ena   <= 1'b1;
          o_state_wea   <= 1'b1;
          o_state_addra <= row_cnt[STATE_ADDR_WIDTH-1:0];
          o_state_dina  <= (row_cnt == '0) ? INIT_ROW0 : '0;
          if ((row_cnt + ROW_ONE) == rows_q) begin
            row_cnt <= '0;
            state   <= S_START;
          end else begin
            row_cnt <= row_cnt + ROW_ONE;
          end
        end
        S_START: begin
          run_cnt <= '0;
          state   <= S_RUN;
        end
        S_RUN: begin
          run_cnt <= run_cnt + 32'd1;
          if (i_complete) begin
            o_run_cycles <= run_cnt + 32'd1;
            state        <= S_READ;
          end else if (timeout_hit) begin
            state <= S_DONE;
          end
        end
        S_READ: begin
          // Issue R addresses, then one extra cycle lets the last row come back
          if (row_cnt < rows_q) begin
            o_state_ena   <= 1'b1;
            o_state_wea   <= 1'b0;
            o_state_addra <= row_cnt[STATE_ADDR_WIDTH-1:0];
            row_cnt       <= row_cnt + ROW_ONE;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qea_run_sequencer.sv
// tb/tb_qea_run_sequencer.sv - scoreboard bench for qea_run_sequencer with a behavioural state RAM
module tb_qea_run_sequencer;

  localparam int TO = 1000;
  localparam logic [255:0] ROW0 = 256'h40000000_00000000 << 192;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_go = 1'b0;
  logic [5:0]   i_qbit_num = '0;
  logic [16:0]  i_ins_num = '0;
  logic         i_ctx_valid = 1'b0;
  logic [63:0]  i_ctx_data = '0;
  logic         o_ctx_ready, o_ctx_en, o_ctx_wea;
  logic [15:0]  o_ctx_addr;
  logic [63:0]  o_ctx_data;
  logic         o_state_ena, o_state_wea;
  logic [15:0]  o_state_addra;
  logic [255:0] o_state_dina;
  logic         o_start;
  logic         i_complete = 1'b0;
  logic [255:0] state_dout;
  logic         o_rd_valid;
  logic [15:0]  o_rd_addr;
  logic [255:0] o_rd_data;
  logic         o_busy, o_done, o_error;
  logic [31:0]  o_run_cycles;

  always #5 clk = ~clk;

  qea_run_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .i_ctx_valid(i_ctx_valid), .i_ctx_data(i_ctx_data), .o_ctx_ready(o_ctx_ready),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .o_state_dina(o_state_dina), .o_start(o_start), .i_complete(i_complete),
    .i_state_dout(state_dout), .o_rd_valid(o_rd_valid), .o_rd_addr(o_rd_addr),
    .o_rd_data(o_rd_data), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_run_cycles(o_run_cycles)
  );

  typedef struct packed {
    logic [16:0]  addr;
    logic [255:0] data;
  } exp_t;

  exp_t exp_ctx[$];
  exp_t exp_init[$];
  exp_t exp_rd[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ctx_wr_cnt = 0, init_wr_cnt = 0, rd_addr_cnt = 0, rd_cnt = 0, en_cnt = 0;
  int done_cyc = 0, last_rd_cyc = 0;

  logic [255:0] mem [0:1023];
  logic         qea_fill = 1'b0;
  logic [31:0]  fill_salt = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, want);
    end
  endtask

  // Stand-in for what the QEA core leaves in the state RAM after a run
  function automatic logic [255:0] row_pat(input int i, input logic [31:0] salt);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = (32'(i) * 32'h9e3779b1) ^ (salt + 32'(w) * 32'h01000193);
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (qea_fill) begin
      for (int i = 0; i < 1024; i++) mem[i] <= row_pat(i, fill_salt);
    end else if (o_state_ena) begin
      if (o_state_wea) mem[o_state_addra[9:0]] <= o_state_dina;
      else state_dout <= mem[o_state_addra[9:0]];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_ctx_en || o_state_ena) en_cnt++;
      if (o_ctx_en) begin
        ctx_wr_cnt++;
        chkb("ctx_wea", o_ctx_wea, 1'b1);
        if (exp_ctx.size() == 0) chki("ctx_unexpected", 1, 0);
        else begin
          e = exp_ctx.pop_front();
          chk("ctx_addr", 256'(o_ctx_addr), 256'(e.addr));
          chk("ctx_data", 256'(o_ctx_data), e.data);
        end
      end
      if (o_state_ena && o_state_wea) begin
        init_wr_cnt++;
        if (exp_init.size() == 0) chki("init_unexpected", 1, 0);
        else begin
          e = exp_init.pop_front();
          chk("init_addr", 256'(o_state_addra), 256'(e.addr));
          chk("init_row", o_state_dina, e.data);
        end
      end
      if (o_state_ena && !o_state_wea) rd_addr_cnt++;
      if (o_rd_valid) begin
        rd_cnt++;
        last_rd_cyc = cyc;
        if (exp_rd.size() == 0) chki("rd_unexpected", 1, 0);
        else begin
          e = exp_rd.pop_front();
          chk("rd_addr", 256'(o_rd_addr), 256'(e.addr));
          chk("rd_data", o_rd_data, e.data);
        end
      end
      if (o_done) done_cyc = cyc;
    end
  end

  task automatic chk_outputs_zero();
    chk("zero_ctrl", 256'({o_ctx_ready, o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea, o_start,
                            o_rd_valid, o_busy, o_done, o_error}), 256'(0));
    chk("zero_addr", 256'({o_ctx_addr, o_state_addra, o_rd_addr}), 256'(0));
    chk("zero_ctx_data", 256'(o_ctx_data), 256'(0));
    chk("zero_dina", o_state_dina, 256'(0));
    chk("zero_rd_data", o_rd_data, 256'(0));
    chk("zero_run_cycles", 256'(o_run_cycles), 256'(0));
  endtask

  // cdelay > 0: raise i_complete that many cycles after o_start; cdelay < 0: never complete
  task automatic run_flow(input int qbit, input int ins, input int vmode, input int cdelay,
                          input logic [31:0] salt);
    int rows, k, n, c0, i0, r0, ra0;
    rows = 1 << (qbit - 2);
    c0 = ctx_wr_cnt; i0 = init_wr_cnt; r0 = rd_cnt; ra0 = rd_addr_cnt;
    for (int r = 0; r < rows; r++) exp_init.push_back('{addr: 17'(r), data: (r == 0) ? ROW0 : '0});
    @(negedge clk);
    i_qbit_num = 6'(qbit); i_ins_num = 17'(ins); i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    chkb("go_busy", o_busy, 1'b1);
    k = 0; n = 0;
    while (k < ins && n < 4 * ins + 10) begin
      i_ctx_valid = (vmode == 0) || (n % 2 == 0);
      i_ctx_data = {$urandom, $urandom};
      if (i_ctx_valid && o_ctx_ready) begin
        exp_ctx.push_back('{addr: 17'(k), data: 256'(i_ctx_data)});
        k++;
      end
      @(negedge clk);
      n++;
    end
    i_ctx_valid = 1'b0;
    chki("ctx_accepted", k, ins);
    chki("ctx_cycles", n, (vmode == 0) ? ins : 2 * ins - 1);
    n = 0;
    while (!o_start && n < rows + 20) begin
      @(negedge clk);
      n++;
    end
    chkb("start_seen", o_start, 1'b1);
    chkb("start_busy", o_busy, 1'b1);
    qea_fill = 1'b1; fill_salt = salt;
    @(negedge clk);
    qea_fill = 1'b0;
    chkb("start_pulse", o_start, 1'b0);
    chki("ctx_writes", ctx_wr_cnt - c0, ins);
    chki("ctx_queue", exp_ctx.size(), 0);
    chki("init_writes", init_wr_cnt - i0, rows);
    chki("init_queue", exp_init.size(), 0);
    if (cdelay > 0) begin
      for (int r = 0; r < rows; r++) exp_rd.push_back('{addr: 17'(r), data: row_pat(r, salt)});
      repeat (cdelay - 1) @(negedge clk);
      i_complete = 1'b1;
      n = 0;
      while (!o_done && n < rows + 20) begin
        @(negedge clk);
        n++;
      end
      chkb("done_seen", o_done, 1'b1);
      i_complete = 1'b0;
      @(negedge clk);
      chki("run_cycles", int'(o_run_cycles), cdelay);
      chki("rd_rows", rd_cnt - r0, rows);
      chki("rd_addrs", rd_addr_cnt - ra0, rows);
      chki("rd_queue", exp_rd.size(), 0);
      chkb("done_after_rd", (done_cyc >= last_rd_cyc) && (done_cyc - last_rd_cyc <= 1), 1'b1);
      chkb("done_pulse", o_done, 1'b0);
      chkb("idle_busy", o_busy, 1'b0);
    end else begin
      n = 0;
      while (!o_error && n < TO + 20) begin
        @(negedge clk);
        n++;
      end
      chkb("timeout_err", o_error, 1'b1);
      chki("timeout_cycle", n + 1, TO);
      @(negedge clk);
      chkb("timeout_done", o_done, 1'b1);
      chkb("timeout_err_pulse", o_error, 1'b0);
      @(negedge clk);
      chki("timeout_no_rd", rd_cnt - r0, 0);
      chki("timeout_no_rd_addr", rd_addr_cnt - ra0, 0);
      chkb("timeout_idle", o_busy, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int qbits[2];
    repeat (3) @(negedge clk);
    chk_outputs_zero();
    rst_n = 1'b1;

    run_flow(10, 331, 0, 50, 32'h1234_5678);
    run_flow(10, 331, 1, 7, 32'hcafe_f00d);

    qbits[0] = 1; qbits[1] = 19;
    foreach (qbits[q]) begin
      e0 = en_cnt;
      @(negedge clk);
      i_qbit_num = 6'(qbits[q]); i_ins_num = 17'd4; i_go = 1'b1;
      @(negedge clk);
      i_go = 1'b0;
      chkb("bad_qbit_err", o_error, 1'b1);
      chkb("bad_qbit_busy", o_busy, 1'b0);
      @(negedge clk);
      chkb("bad_qbit_pulse", o_error, 1'b0);
      chkb("bad_qbit_idle", o_busy, 1'b0);
      repeat (3) @(negedge clk);
      chki("bad_qbit_no_en", en_cnt - e0, 0);
    end

    run_flow(4, 2, 0, -1, 32'h0);

    for (int r = 0; r < 256; r++) exp_init.push_back('{addr: 17'(r), data: (r == 0) ? ROW0 : '0});
    @(negedge clk);
    i_qbit_num = 6'd10; i_ins_num = 17'd0; i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    chkb("ins0_busy", o_busy, 1'b1);
    chkb("ins0_no_ready", o_ctx_ready, 1'b0);
    @(negedge clk);
    chkb("ins0_init_en", o_state_ena & o_state_wea, 1'b1);
    chk("ins0_init_addr", 256'(o_state_addra), 256'(0));
    chki("ins0_no_ctx", ctx_wr_cnt, 331 * 2 + 2);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero();
    exp_init.delete();
    exp_ctx.delete();
    exp_rd.delete();
    repeat (2) @(negedge clk);
    chk_outputs_zero();
    rst_n = 1'b1;
    run_flow(2, 3, 0, 5, 32'h0bad_beef);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
